ssp_overlay_compositor: RTL and testbench
=========================================

Name: ssp_overlay_compositor

Overview:
Parametrised successor to the SuperSprite single-VDP overlay path. Composites up to four VDP-class overlay layers over Apple II base video, with a per-layer keying mode, strict layer priority and a frame-stepped brightness fade. Its register bank is written from the slot device-select decode and mirrors the legacy soft switches at offsets $3-$6. It sits between the VDP/sprite engines and the HDMI/VGA pixel path.

Parameters:
LAYERS, 2, number of overlay layers (1-4); layer 0 has highest priority.
COLOR_W, 4, bits per channel of each layer pixel (4-8).
FORCE_OVERLAY, 0, reset and "apple out" value of overlay_sw.

Ports:
clk_logic_i  in  1  logic/pixel clock; all state on rising edge
reset_i  in  1  asynchronous, active-high reset
reg_wr_i  in  1  single-cycle register write strobe (already qualified by card/dev select)
reg_addr_i  in  4  register offset
reg_data_i  in  8  write data
reg_rd_data_o  out  8  combinational readback of reg_addr_i
frame_start_i  in  1  one-cycle pulse per frame
pixel_valid_i  in  1  pixel inputs are valid this cycle
base_r_i/base_g_i/base_b_i  in  8 each  Apple video
layer_rgb_i  in  LAYERS*3*COLOR_W  packed {r,g,b} per layer; layer 0 is the LSBs
layer_transparent_i  in  LAYERS  per-layer transparent flag
pix_r_o/pix_g_o/pix_b_o  out  8 each  composited pixel
pixel_valid_o  out  1  pixel_valid_i delayed by 2 cycles
overlay_active_o  out  1  overlay_sw state

Behaviour:
- Register map:
  - $0 control: [0]=overlay_sw, [1]=apple_video_sw.
  - $1 chroma key: [7:4]=R, [3:0]=G.
  - $2 chroma key: [3:0]=B.
  - $3 apple_video_sw<=0. $4 apple_video_sw<=1. $5 overlay_sw<=FORCE_OVERLAY. $6 overlay_sw<=1. These are strobes; write data is ignored.
  - $7 fade: [4:0]=target (values >16 clamp to 16), [7:5]=rate.
  - $8+n layer n mode [1:0]: 0=off, 1=black-key, 2=transparent-flag, 3=chroma-key.
  - Writes to n>=LAYERS, and to $C-$F, are ignored.
- Readback returns the stored fields, zero-filled. Strobe addresses read back {6'b0, apple_video_sw, overlay_sw}. Unused addresses read 0.
- Reset values:
  - overlay_sw=FORCE_OVERLAY, apple_video_sw=1.
  - All layer modes=1, chroma=0.
  - fade level=16, target=16, rate=0, frame counter=0.
  - pix_*_o=0, pixel_valid_o=0.
- Layer hit rules (a layer hits when its pixel is shown):
  - mode 1: any channel is nonzero.
  - mode 2: !layer_transparent_i[n].
  - mode 3: the top 4 bits of each channel equal the chroma R/G/B, and the hit is inverted (the key colour is see-through).
  - mode 0: never hits.
- Pipeline stage 1 registers:
  - the layer pixels, each zero-padded left-aligned to 8 bits;
  - the per-layer hit vector ANDed with overlay_sw;
  - the base pixel, forced to 0 when apple_video_sw=0;
  - pixel_valid.
- Pipeline stage 2 selects the lowest-index hitting layer, else base. Each channel is then scaled as (ch*level)>>4 with a 13-bit product. The result and pixel_valid_o are registered.
- Latency is exactly 2 cycles. Outputs update every cycle regardless of valid.
- Fade:
  - On frame_start_i the frame counter increments.
  - When counter==rate, the counter clears and level moves one step toward target (+1 or -1). If level==target, level holds.
  - level 16 = identity; level 0 = black.
- A register write in the same cycle as frame_start_i commits the write. That frame's fade step uses the pre-write target and rate.
- Retargeting mid-fade continues from the current level; there is no jump.
- Reset mid-frame clears the pipeline immediately. pixel_valid_o=0 until 2 cycles after the first valid pixel.

Optional Feature:
SSP_CHROMA_KEY_EN:
- Defined: the chroma registers $1/$2 and mode 3 are implemented as above.
- Undefined: $1/$2 writes are ignored and read 0. Mode 3 is stored and read back as written but behaves as mode 0 (never hits). The chroma comparators are not built.

Test Plan:
1. Reset, then one valid pixel with base=($40,$50,$60) and all layers black -> pixel_valid_o is high 2 cycles later; output=($40,$50,$60); overlay_sw=0.
2. Write $6. Layer0=(4'hF,0,0) mode 1, layer1=(0,4'hF,0) mode 2 not transparent -> output ($F0,0,0) (layer 0 wins). Set layer0 to black -> output ($00,$F0,$00).
3. Write $3, then present a black layer 0 over base $FF -> output (0,0,0). Write $4 -> output $FF.
4. Write $7=$00 (target 0, rate 0), then 16 frame_start pulses with base $FF -> level steps 16->0 one per frame. After 8 pulses the output is $7F. After 16 pulses it is 0, and the 17th pulse has no change.
5. Write $7=$30 (rate 1, target 16) from level 0 -> level increments every 2nd frame_start. A same-cycle write of target 0 with frame_start still steps up once, then steps down.
6. (SSP_CHROMA_KEY_EN) Chroma=$F0,$0. Layer0 mode 3 with pixel (F,0,0) -> base shown. With pixel (F,1,0) -> layer shown. Without the macro, mode 3 always shows base and $1 reads 0.

Source files
------------

// File: rtl/ssp_overlay_compositor.sv
// SuperSprite overlay compositor: up to four keyed overlay layers over Apple II video, strict priority, frame-stepped fade.
// Optional build macro SSP_CHROMA_KEY_EN adds the chroma-key registers ($1/$2) and the mode-3 comparators.
module ssp_overlay_compositor #(
  parameter int LAYERS        = 2,
  parameter int COLOR_W       = 4,
  parameter int FORCE_OVERLAY = 0
) (
  input  logic                          clk_logic_i,
  input  logic                          reset_i,
  input  logic                          reg_wr_i,
  input  logic [3:0]                    reg_addr_i,
  input  logic [7:0]                    reg_data_i,
  output logic [7:0]                    reg_rd_data_o,
  input  logic                          frame_start_i,
  input  logic                          pixel_valid_i,
  input  logic [7:0]                    base_r_i,
  input  logic [7:0]                    base_g_i,
  input  logic [7:0]                    base_b_i,
  input  logic [LAYERS*3*COLOR_W-1:0]   layer_rgb_i,
  input  logic [LAYERS-1:0]             layer_transparent_i,
  output logic [7:0]                    pix_r_o,
  output logic [7:0]                    pix_g_o,
  output logic [7:0]                    pix_b_o,
  output logic                          pixel_valid_o,
  output logic                          overlay_active_o
);

  localparam logic FORCE_SW = (FORCE_OVERLAY != 0);

  logic       overlay_sw, apple_video_sw;
  logic [1:0] layer_mode [LAYERS];
  logic [4:0] fade_target, fade_level;
  logic [2:0] fade_rate, frame_cnt;
`ifdef SSP_CHROMA_KEY_EN
  logic [3:0] chroma_r, chroma_g, chroma_b;
`endif

  logic [7:0]        lay_r [LAYERS];
  logic [7:0]        lay_g [LAYERS];
  logic [7:0]        lay_b [LAYERS];
  logic [LAYERS-1:0] hit;

  logic [7:0]        s1_r [LAYERS];
  logic [7:0]        s1_g [LAYERS];
  logic [7:0]        s1_b [LAYERS];
  logic [LAYERS-1:0] s1_hit;
  logic [7:0]        s1_base_r, s1_base_g, s1_base_b;
  logic              s1_valid;
  logic [7:0]        sel_r, sel_g, sel_b;

  // Register bank; offsets $3-$6 are legacy soft-switch strobes that ignore the data byte.
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      overlay_sw     <= FORCE_SW;
      apple_video_sw <= 1'b1;
      fade_target    <= 5'd16;
      fade_rate      <= 3'd0;
      for (int n = 0; n < LAYERS; n++) layer_mode[n] <= 2'd1;
`ifdef SSP_CHROMA_KEY_EN
      chroma_r <= '0;
      chroma_g <= '0;
      chroma_b <= '0;
`endif
    end else if (reg_wr_i) begin
      case (reg_addr_i)
        4'h0: begin
          overlay_sw     <= reg_data_i[0];
          apple_video_sw <= reg_data_i[1];
        end
`ifdef SSP_CHROMA_KEY_EN
        4'h1: begin
          chroma_r <= reg_data_i[7:4];
          chroma_g <= reg_data_i[3:0];
        end
        4'h2: chroma_b <= reg_data_i[3:0];
`endif
        4'h3: apple_video_sw <= 1'b0;
        4'h4: apple_video_sw <= 1'b1;
        4'h5: overlay_sw     <= FORCE_SW;
        4'h6: overlay_sw     <= 1'b1;
        4'h7: begin
          fade_target <= (reg_data_i[4:0] > 5'd16) ? 5'd16 : reg_data_i[4:0];
          fade_rate   <= reg_data_i[7:5];
        end
        default: begin
          for (int n = 0; n < LAYERS; n++)
            if (reg_addr_i == 4'(8 + n)) layer_mode[n] <= reg_data_i[1:0];
        end
      endcase
    end
  end

  // Fade steps use the registers as they stood before any same-cycle write.
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      fade_level <= 5'd16;
      frame_cnt  <= 3'd0;
    end else if (frame_start_i) begin
      if (frame_cnt == fade_rate) begin
        frame_cnt <= 3'd0;
        if (fade_level < fade_target)      fade_level <= fade_level + 5'd1;
        else if (fade_level > fade_target) fade_level <= fade_level - 5'd1;
      end else begin
        frame_cnt <= frame_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    reg_rd_data_o = '0;
    case (reg_addr_i)
      4'h0, 4'h3, 4'h4, 4'h5, 4'h6: reg_rd_data_o = {6'b0, apple_video_sw, overlay_sw};
`ifdef SSP_CHROMA_KEY_EN
      4'h1: reg_rd_data_o = {chroma_r, chroma_g};
      4'h2: reg_rd_data_o = {4'b0, chroma_b};
`endif
      4'h7: reg_rd_data_o = {fade_rate, fade_target};
      default: begin
        for (int n = 0; n < LAYERS; n++)
          if (reg_addr_i == 4'(8 + n)) reg_rd_data_o = {6'b0, layer_mode[n]};
      end
    endcase
  end

  // Layer pixels are widened left-aligned so the chroma key always compares the top nibble.
  always_comb begin
    for (int n = 0; n < LAYERS; n++) begin
      lay_r[n] = '0;
      lay_g[n] = '0;
      lay_b[n] = '0;
      lay_r[n][7 -: COLOR_W] = layer_rgb_i[n*3*COLOR_W + 2*COLOR_W +: COLOR_W];
      lay_g[n][7 -: COLOR_W] = layer_rgb_i[n*3*COLOR_W + COLOR_W +: COLOR_W];
      lay_b[n][7 -: COLOR_W] = layer_rgb_i[n*3*COLOR_W +: COLOR_W];
      hit[n] = 1'b0;
      case (layer_mode[n])
        2'd1: hit[n] = |{lay_r[n], lay_g[n], lay_b[n]};
        2'd2: hit[n] = !layer_transparent_i[n];
`ifdef SSP_CHROMA_KEY_EN
        2'd3: hit[n] = !((lay_r[n][7:4] == chroma_r) && (lay_g[n][7:4] == chroma_g) &&
                         (lay_b[n][7:4] == chroma_b));
`endif
        default: hit[n] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      for (int n = 0; n < LAYERS; n++) begin
        s1_r[n] <= '0;
        s1_g[n] <= '0;
        s1_b[n] <= '0;
      end
      s1_hit    <= '0;
      s1_base_r <= '0;
      s1_base_g <= '0;
      s1_base_b <= '0;
      s1_valid  <= 1'b0;
    end else begin
      s1_r      <= lay_r;
      s1_g      <= lay_g;
      s1_b      <= lay_b;
      s1_hit    <= hit & {LAYERS{overlay_sw}};
      s1_base_r <= apple_video_sw ? base_r_i : 8'd0;
      s1_base_g <= apple_video_sw ? base_g_i : 8'd0;
      s1_base_b <= apple_video_sw ? base_b_i : 8'd0;
      s1_valid  <= pixel_valid_i;
    end
  end

  // Walk from lowest priority upward so the lowest-index hitting layer lands last.
  always_comb begin
    sel_r = s1_base_r;
    sel_g = s1_base_g;
    sel_b = s1_base_b;
    for (int n = LAYERS - 1; n >= 0; n--) begin
      if (s1_hit[n]) begin
        sel_r = s1_r[n];
        sel_g = s1_g[n];
        sel_b = s1_b[n];
      end
    end
  end

  function automatic logic [7:0] scale(input logic [7:0] ch, input logic [4:0] level);
    logic [12:0] prod;
    prod = {5'b0, ch} * {8'b0, level};
    return 8'(prod >> 4);
  endfunction

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      pix_r_o       <= '0;
      pix_g_o       <= '0;
      pix_b_o       <= '0;
      pixel_valid_o <= 1'b0;
    end else begin
      pix_r_o       <= scale(sel_r, fade_level);
      pix_g_o       <= scale(sel_g, fade_level);
      pix_b_o       <= scale(sel_b, fade_level);
      pixel_valid_o <= s1_valid;
    end
  end

  assign overlay_active_o = overlay_sw;

endmodule

// File: tb/tb_ssp_overlay_compositor.sv
// Self-checking bench for ssp_overlay_compositor: register vectors, directed compositing/fade sequences, random pixels.
// Expectations follow SSP_CHROMA_KEY_EN the same way the design does.
module tb_ssp_overlay_compositor;

  localparam int LAYERS  = 2;
  localparam int COLOR_W = 4;
  localparam int LW      = LAYERS * 3 * COLOR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              reg_wr;
  logic [3:0]        reg_addr;
  logic [7:0]        reg_data;
  logic [7:0]        reg_rd;
  logic              frame_start;
  logic              pv_in;
  logic [7:0]        base_r, base_g, base_b;
  logic [LW-1:0]     layer_rgb;
  logic [LAYERS-1:0] layer_transparent;
  logic [7:0]        pix_r, pix_g, pix_b;
  logic              pv_out;
  logic              ov_active;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ssp_overlay_compositor #(.LAYERS(LAYERS), .COLOR_W(COLOR_W), .FORCE_OVERLAY(0)) dut (
    .clk_logic_i(clk), .reset_i(rst),
    .reg_wr_i(reg_wr), .reg_addr_i(reg_addr), .reg_data_i(reg_data), .reg_rd_data_o(reg_rd),
    .frame_start_i(frame_start), .pixel_valid_i(pv_in),
    .base_r_i(base_r), .base_g_i(base_g), .base_b_i(base_b),
    .layer_rgb_i(layer_rgb), .layer_transparent_i(layer_transparent),
    .pix_r_o(pix_r), .pix_g_o(pix_g), .pix_b_o(pix_b),
    .pixel_valid_o(pv_out), .overlay_active_o(ov_active)
  );

  // Reference model state, kept in plain integers.
  bit m_ov, m_ap;
  int m_mode [4];
  int m_cr, m_cg, m_cb, m_target, m_rate, m_level, m_cnt;
  int lr [4], lg [4], lb [4];
  bit lt [4];

  typedef struct {
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] ra;
    logic [7:0] rexp;
  } reg_vec_t;

  reg_vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0;
    m_ap = 1'b1;
    for (int n = 0; n < 4; n++) m_mode[n] = 1;
    m_cr = 0; m_cg = 0; m_cb = 0;
    m_target = 16; m_rate = 0; m_level = 16; m_cnt = 0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    int t;
    case (a)
      4'h0: begin m_ov = d[0]; m_ap = d[1]; end
`ifdef SSP_CHROMA_KEY_EN
      4'h1: begin m_cr = int'(d[7:4]); m_cg = int'(d[3:0]); end
      4'h2: m_cb = int'(d[3:0]);
`endif
      4'h3: m_ap = 1'b0;
      4'h4: m_ap = 1'b1;
      4'h5: m_ov = 1'b0;
      4'h6: m_ov = 1'b1;
      4'h7: begin
        t = int'(d[4:0]);
        m_target = (t > 16) ? 16 : t;
        m_rate   = int'(d[7:5]);
      end
      default: if (a >= 4'h8 && int'(a) - 8 < LAYERS) m_mode[int'(a) - 8] = int'(d[1:0]);
    endcase
  endtask

  task automatic model_fade_step();
    if (m_cnt == m_rate) begin
      m_cnt = 0;
      if (m_level < m_target) m_level++;
      else if (m_level > m_target) m_level--;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic bit layer_hits(input int n);
    int sh = 8 - COLOR_W;
    case (m_mode[n])
      1: return (lr[n] | lg[n] | lb[n]) != 0;
      2: return !lt[n];
`ifdef SSP_CHROMA_KEY_EN
      3: return !((((lr[n] << sh) >> 4) == m_cr) && (((lg[n] << sh) >> 4) == m_cg) &&
                  (((lb[n] << sh) >> 4) == m_cb));
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [23:0] model_pixel(input int br, input int bg, input int bb);
    int r, g, b;
    bit found;
    int sh = 8 - COLOR_W;
    r = m_ap ? br : 0;
    g = m_ap ? bg : 0;
    b = m_ap ? bb : 0;
    found = 1'b0;
    if (m_ov)
      for (int n = 0; n < LAYERS; n++)
        if (!found && layer_hits(n)) begin
          found = 1'b1;
          r = lr[n] << sh;
          g = lg[n] << sh;
          b = lb[n] << sh;
        end
    r = (r * m_level) / 16;
    g = (g * m_level) / 16;
    b = (b * m_level) / 16;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic apply_stimulus(input int br, input int bg, input int bb, input bit valid);
    logic [LW-1:0] v;
    v = '0;
    for (int n = 0; n < LAYERS; n++) begin
      v[n*3*COLOR_W +: 3*COLOR_W] = {COLOR_W'(lr[n]), COLOR_W'(lg[n]), COLOR_W'(lb[n])};
      layer_transparent[n] = lt[n];
    end
    layer_rgb = v;
    base_r = 8'(br);
    base_g = 8'(bg);
    base_b = 8'(bb);
    pv_in  = valid;
  endtask

  task automatic check_output(input string name, input logic [23:0] exp_pix, input bit exp_valid);
    check(name, {7'b0, pv_out, pix_r, pix_g, pix_b}, {7'b0, exp_valid, exp_pix});
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    reg_wr   = 1'b1;
    reg_addr = a;
    reg_data = d;
    tick();
    reg_wr = 1'b0;
    model_write(a, d);
  endtask

  task automatic frame_pulse(input bit with_wr, input logic [3:0] a, input logic [7:0] d);
    frame_start = 1'b1;
    if (with_wr) begin
      reg_wr   = 1'b1;
      reg_addr = a;
      reg_data = d;
    end
    tick();
    frame_start = 1'b0;
    reg_wr      = 1'b0;
    model_fade_step();
    if (with_wr) model_write(a, d);
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    check(name, {24'b0, reg_rd}, {24'b0, exp});
  endtask

  task automatic clear_layers();
    for (int n = 0; n < 4; n++) begin
      lr[n] = 0; lg[n] = 0; lb[n] = 0; lt[n] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] exp_pix [40];
    bit          exp_v   [40];
    bit          vb;
    int          br, bg, bb;

    vecs[0]  = '{4'h0, 8'h03, 4'h0, 8'h03};
    vecs[1]  = '{4'h0, 8'h00, 4'h3, 8'h00};
    vecs[2]  = '{4'h4, 8'h00, 4'h0, 8'h02};
    vecs[3]  = '{4'h6, 8'h00, 4'h5, 8'h03};
    vecs[4]  = '{4'h5, 8'hFF, 4'h0, 8'h02};
    vecs[5]  = '{4'h3, 8'hFF, 4'h6, 8'h00};
    vecs[6]  = '{4'h7, 8'hFF, 4'h7, 8'hF0};
    vecs[7]  = '{4'h7, 8'h25, 4'h7, 8'h25};
    vecs[8]  = '{4'h9, 8'h03, 4'h9, 8'h03};
    vecs[9]  = '{4'hA, 8'h02, 4'hA, 8'h00};
    vecs[10] = '{4'hC, 8'hFF, 4'hC, 8'h00};
`ifdef SSP_CHROMA_KEY_EN
    vecs[11] = '{4'h1, 8'hA5, 4'h1, 8'hA5};
    vecs[12] = '{4'h2, 8'hFF, 4'h2, 8'h0F};
`else
    vecs[11] = '{4'h1, 8'hA5, 4'h1, 8'h00};
    vecs[12] = '{4'h2, 8'hFF, 4'h2, 8'h00};
`endif
    vecs[13] = '{4'h8, 8'h00, 4'h8, 8'h00};

    rst = 1'b1;
    reg_wr = 1'b0; reg_addr = '0; reg_data = '0; frame_start = 1'b0;
    clear_layers();
    apply_stimulus(0, 0, 0, 1'b0);
    model_reset();
    settle();
    rst = 1'b0;

    // Reset state.
    check_output("reset_pix", 24'h000000, 1'b0);
    check("reset_ov_active", {31'b0, ov_active}, 32'd0);
    read_check("reset_rd0", 4'h0, 8'h02);
    read_check("reset_rd7", 4'h7, 8'h10);
    read_check("reset_rd8", 4'h8, 8'h01);
    read_check("reset_rd9", 4'h9, 8'h01);

    // Register write/readback vectors.
    for (int i = 0; i < 14; i++) begin
      reg_write(vecs[i].wa, vecs[i].wd);
      read_check($sformatf("regvec%0d", i), vecs[i].ra, vecs[i].rexp);
    end
    reg_write(4'h0, 8'h02);
    reg_write(4'h7, 8'h10);
    reg_write(4'h8, 8'h01);
    reg_write(4'h9, 8'h01);
    reg_write(4'h1, 8'h00);
    reg_write(4'h2, 8'h00);

    // Base pixel passes through with 2-cycle latency.
    clear_layers();
    apply_stimulus(8'h40, 8'h50, 8'h60, 1'b1);
    tick();
    pv_in = 1'b0;
    check("lat1_valid_early", {31'b0, pv_out}, 32'd0);
    tick();
    check_output("lat2_pix", 24'h405060, 1'b1);
    tick();
    check("lat3_valid_low", {31'b0, pv_out}, 32'd0);
    check("t1_ov_active", {31'b0, ov_active}, 32'd0);

    // Priority: layer 0 beats layer 1.
    reg_write(4'h6, 8'h00);
    reg_write(4'h9, 8'h02);
    lr[0] = 15; lg[0] = 0; lb[0] = 0;
    lr[1] = 0;  lg[1] = 15; lb[1] = 0;
    apply_stimulus(8'h40, 8'h50, 8'h60, 1'b1);
    settle();
    check_output("prio_l0", 24'hF00000, 1'b1);
    check("t2_ov_active", {31'b0, ov_active}, 32'd1);
    lr[0] = 0;
    apply_stimulus(8'h40, 8'h50, 8'h60, 1'b1);
    settle();
    check_output("prio_l1", 24'h00F000, 1'b1);

    // Apple video switch.
    reg_write(4'h3, 8'h00);
    lt[1] = 1'b1;
    apply_stimulus(8'hFF, 8'hFF, 8'hFF, 1'b1);
    settle();
    check_output("apple_off", 24'h000000, 1'b1);
    reg_write(4'h4, 8'h00);
    settle();
    check_output("apple_on", 24'hFFFFFF, 1'b1);

    // Randomized batches against the reference model at full brightness.
    for (int b = 0; b < 4; b++) begin
      reg_write(4'h0, 8'($urandom_range(0, 3)));
      for (int n = 0; n < LAYERS; n++) reg_write(4'(8 + n), 8'($urandom_range(0, 3)));
      reg_write(4'h1, 8'($urandom));
      reg_write(4'h2, 8'($urandom));
      for (int i = 0; i < 42; i++) begin
        if (i >= 2) check_output($sformatf("rand_b%0d_i%0d", b, i - 2), exp_pix[i-2], exp_v[i-2]);
        if (i < 40) begin
          for (int n = 0; n < LAYERS; n++) begin
            if ($urandom_range(0, 3) == 0) begin
              lr[n] = 0; lg[n] = 0; lb[n] = 0;
            end else if ($urandom_range(0, 2) == 0) begin
              lr[n] = m_cr; lg[n] = m_cg; lb[n] = m_cb;
            end else begin
              lr[n] = $urandom_range(0, 15);
              lg[n] = $urandom_range(0, 15);
              lb[n] = $urandom_range(0, 15);
            end
            lt[n] = $urandom_range(0, 1);
          end
          br = $urandom_range(0, 255);
          bg = $urandom_range(0, 255);
          bb = $urandom_range(0, 255);
          vb = $urandom_range(0, 1);
          apply_stimulus(br, bg, bb, vb);
          exp_pix[i] = model_pixel(br, bg, bb);
          exp_v[i]   = vb;
        end
        tick();
      end
    end

    // Fade down to black, one step per frame.
    reg_write(4'h0, 8'h02);
    clear_layers();
    apply_stimulus(8'hFF, 8'hFF, 8'hFF, 1'b1);
    reg_write(4'h7, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      frame_pulse(1'b0, 4'h0, 8'h00);
      settle();
      check_output($sformatf("fade_down_%0d", k), model_pixel(255, 255, 255), 1'b1);
      if (k == 8)  check("fade_half", {24'b0, pix_r}, 32'h7F);
      if (k == 17) check("fade_hold", {24'b0, pix_r}, 32'h00);
    end

    // Slow fade up, then a same-cycle retarget.
    reg_write(4'h7, 8'h30);
    for (int k = 1; k <= 5; k++) begin
      frame_pulse(1'b0, 4'h0, 8'h00);
      settle();
      check_output($sformatf("fade_up_%0d", k), model_pixel(255, 255, 255), 1'b1);
    end
    frame_pulse(1'b1, 4'h7, 8'h20);
    settle();
    check("fade_same_cycle", {24'b0, pix_r}, 32'h2F);
    for (int k = 1; k <= 2; k++) begin
      frame_pulse(1'b0, 4'h0, 8'h00);
      settle();
      check_output($sformatf("fade_retgt_%0d", k), model_pixel(255, 255, 255), 1'b1);
    end
    check("fade_back_down", {24'b0, pix_r}, 32'h1F);

    // Reset with pixels in flight.
    apply_stimulus(8'hAA, 8'hBB, 8'hCC, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check_output("midreset_clear", 24'h000000, 1'b0);
    rst = 1'b0;
    model_reset();
    apply_stimulus(8'h12, 8'h34, 8'h56, 1'b0);
    tick();
    apply_stimulus(8'h12, 8'h34, 8'h56, 1'b1);
    tick();
    check("postreset_valid_low", {31'b0, pv_out}, 32'd0);
    tick();
    check_output("postreset_first", 24'h123456, 1'b1);

    // Chroma key.
    reg_write(4'h6, 8'h00);
    reg_write(4'h1, 8'hF0);
    reg_write(4'h2, 8'h00);
    reg_write(4'h8, 8'h03);
    reg_write(4'h9, 8'h00);
    clear_layers();
    lr[0] = 15;
    apply_stimulus(8'h12, 8'h34, 8'h56, 1'b1);
    settle();
    check_output("chroma_keyed", 24'h123456, 1'b1);
    lg[0] = 1;
    apply_stimulus(8'h12, 8'h34, 8'h56, 1'b1);
    settle();
`ifdef SSP_CHROMA_KEY_EN
    check_output("chroma_shown", 24'hF01000, 1'b1);
    read_check("chroma_rd1", 4'h1, 8'hF0);
`else
    check_output("chroma_shown", 24'h123456, 1'b1);
    read_check("chroma_rd1", 4'h1, 8'h00);
`endif
    read_check("mode3_rd8", 4'h8, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
